// File: rtl/rotate_sdram_bridge.sv
// Burst arbiter between the rotating scandoubler's write/read streams and a word-level SDRAM port.
// Optional starve statistics are built only when ROTATE_BRIDGE_STATS_EN is defined.
module rotate_sdram_bridge #(
    parameter int unsigned ROW_BITS   = 10,
    parameter int unsigned COL_BITS   = 10,
    parameter int unsigned STARVE_MAX = 255
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic                         vidin_req,
    input  logic [1:0]                   vidin_frame,
    input  logic [10:0]                  vidin_row,
    input  logic [10:0]                  vidin_col,
    input  logic [15:0]                  vidin_d,
    output logic                         vidin_ack,
    input  logic                         vidout_req,
    input  logic [1:0]                   vidout_frame,
    input  logic [10:0]                  vidout_row,
    input  logic [10:0]                  vidout_col,
    output logic [15:0]                  vidout_d,
    output logic                         vidout_ack,
    output logic                         ram_req,
    output logic                         ram_we,
    output logic [2+ROW_BITS+COL_BITS-1:0] ram_addr,
    output logic [15:0]                  ram_wdata,
    input  logic                         ram_ack,
    input  logic [15:0]                  ram_rdata,
    output logic [15:0]                  stat_starve
);

    localparam int unsigned AW = 2 + ROW_BITS + COL_BITS;

    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_SETTLE, RD_ISSUE, RD_SETTLE} state_t;

    state_t        state;
    logic [3:0]    wr_cnt;
    logic [3:0]    rd_cnt;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    assign wr_addr = {vidin_frame, vidin_row[ROW_BITS-1:0], vidin_col[COL_BITS-1:0]};
    assign rd_addr = {vidout_frame, vidout_row[ROW_BITS-1:0], vidout_col[COL_BITS-1:0]};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_cnt     <= 4'd0;
            rd_cnt     <= 4'd0;
            ram_req    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= 16'd0;
            vidin_ack  <= 1'b0;
            vidout_ack <= 1'b0;
            vidout_d   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (vidin_req) begin
                        state     <= WR_ISSUE;
                        ram_req   <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_addr  <= wr_addr;
                        ram_wdata <= vidin_d;
                        wr_cnt    <= 4'd0;
                    end else if (vidout_req) begin
                        state    <= RD_ISSUE;
                        ram_req  <= 1'b1;
                        ram_we   <= 1'b0;
                        ram_addr <= rd_addr;
                        rd_cnt   <= 4'd0;
                    end
                end
                WR_ISSUE: begin
                    if (ram_ack) begin
                        state     <= WR_SETTLE;
                        ram_req   <= 1'b0;
                        ram_we    <= 1'b0;
                        vidin_ack <= 1'b1;
                        wr_cnt    <= wr_cnt + 4'd1;
                    end
                end
                WR_SETTLE: begin
                    vidin_ack <= 1'b0;
                    // wr_cnt wraps to 0 after the 16th word, closing the burst
                    if (vidin_req && wr_cnt != 4'd0) begin
                        state     <= WR_ISSUE;
                        ram_req   <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_addr  <= wr_addr;
                        ram_wdata <= vidin_d;
                    end else begin
                        state <= IDLE;
                    end
                end
                RD_ISSUE: begin
                    if (ram_ack) begin
                        state      <= RD_SETTLE;
                        ram_req    <= 1'b0;
                        vidout_d   <= ram_rdata;
                        vidout_ack <= 1'b1;
                        rd_cnt     <= rd_cnt + 4'd1;
                    end
                end
                RD_SETTLE: begin
                    vidout_ack <= 1'b0;
                    if (vidout_req && rd_cnt < 4'd8) begin
                        state    <= RD_ISSUE;
                        ram_req  <= 1'b1;
                        ram_we   <= 1'b0;
                        ram_addr <= rd_addr;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROTATE_BRIDGE_STATS_EN
    logic [15:0] starve_wait;
    logic        starved;
    logic        in_wr;

    assign in_wr = (state == WR_ISSUE) || (state == WR_SETTLE);

    // One increment per waiting episode; the flag clears once the writer is served
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            starve_wait <= 16'd0;
            starved     <= 1'b0;
            stat_starve <= 16'd0;
        end else if (vidin_req && !in_wr) begin
            if (starve_wait != 16'hFFFF) begin
                starve_wait <= starve_wait + 16'd1;
            end
            if (32'(starve_wait) >= STARVE_MAX && !starved) begin
                starved <= 1'b1;
                if (stat_starve != 16'hFFFF) begin
                    stat_starve <= stat_starve + 16'd1;
                end
            end
        end else begin
            starve_wait <= 16'd0;
            starved     <= 1'b0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{vidin_row, vidin_col, vidout_row, vidout_col};
`else
    assign stat_starve = 16'd0;

    logic unused_bits;
    assign unused_bits = ^{vidin_row, vidin_col, vidout_row, vidout_col, (STARVE_MAX != 0)};
`endif

endmodule

// File: tb/tb_rotate_sdram_bridge.sv
// Self-checking bench for rotate_sdram_bridge: randomized bursts against a queue-based stream model.
module tb_rotate_sdram_bridge;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        vidin_req = 1'b0;
    logic [1:0]  vidin_frame = 2'd0;
    logic [10:0] vidin_row = 11'd0;
    logic [10:0] vidin_col = 11'd0;
    logic [15:0] vidin_d = 16'd0;
    logic        vidin_ack;
    logic        vidout_req = 1'b0;
    logic [1:0]  vidout_frame = 2'd0;
    logic [10:0] vidout_row = 11'd0;
    logic [10:0] vidout_col = 11'd0;
    logic [15:0] vidout_d;
    logic        vidout_ack;
    logic        ram_req;
    logic        ram_we;
    logic [21:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_ack = 1'b0;
    logic [15:0] ram_rdata = 16'd0;
    logic [15:0] stat_starve;

    int checks = 0;
    int errors = 0;
    int lat = 2;

    logic [37:0] wexp[$];
    logic [21:0] rexp[$];
    logic        we_order[$];
    int          gaps[$];
    time         last_wr_ack = 0;
    time         last_rd_ack = 0;

    rotate_sdram_bridge #(.ROW_BITS(10), .COL_BITS(10), .STARVE_MAX(4)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .vidin_req(vidin_req), .vidin_frame(vidin_frame), .vidin_row(vidin_row),
        .vidin_col(vidin_col), .vidin_d(vidin_d), .vidin_ack(vidin_ack),
        .vidout_req(vidout_req), .vidout_frame(vidout_frame), .vidout_row(vidout_row),
        .vidout_col(vidout_col), .vidout_d(vidout_d), .vidout_ack(vidout_ack),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata), .stat_starve(stat_starve)
    );

    always #5 clk_sys = ~clk_sys;

    // SDRAM responder: acks each request lat cycles after it appears; pops expected streams
    int          cnt = 0;
    int          lowcnt = 0;
    logic [38:0] first_word;
    logic [37:0] wx;
    logic [21:0] rx;
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            ram_ack = 1'b0;
            cnt = 0;
        end else if (ram_ack) begin
            ram_ack = 1'b0;
            cnt = 0;
            lowcnt = 1;
        end else if (ram_req) begin
            if (cnt == 0) begin
                gaps.push_back(lowcnt);
                we_order.push_back(ram_we);
                first_word = {ram_we, ram_addr, ram_wdata};
            end else begin
                checks++;
                if ({ram_we, ram_addr, ram_wdata} !== first_word) begin
                    errors++;
                    $display("FAIL req_stable got %h want %h", {ram_we, ram_addr, ram_wdata},
                             first_word);
                end
            end
            cnt++;
            if (cnt >= lat) begin
                ram_ack = 1'b1;
                ram_rdata = 16'hA000 + {6'd0, ram_addr[9:0]};
                checks++;
                if (ram_we) begin
                    last_wr_ack = $time;
                    if (wexp.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write got %h want none", {ram_addr, ram_wdata});
                    end else begin
                        wx = wexp.pop_front();
                        if ({ram_addr, ram_wdata} !== wx) begin
                            errors++;
                            $display("FAIL write_txn got %h want %h", {ram_addr, ram_wdata}, wx);
                        end
                    end
                end else begin
                    last_rd_ack = $time;
                    if (rexp.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_read got %h want none", ram_addr);
                    end else begin
                        rx = rexp.pop_front();
                        if (ram_addr !== rx) begin
                            errors++;
                            $display("FAIL read_addr got %h want %h", ram_addr, rx);
                        end
                    end
                end
            end
        end else begin
            lowcnt++;
        end
    end

    // Upstream acks are mutually exclusive and never back to back
    logic prev_in = 1'b0;
    logic prev_out = 1'b0;
    always @(negedge clk_sys) begin
        if (reset_n) begin
            checks++;
            if ((vidin_ack && vidout_ack) || (vidin_ack && prev_in) || (vidout_ack && prev_out)) begin
                errors++;
                $display("FAIL ack_exclusive got in=%b out=%b prev=%b%b want single pulses",
                         vidin_ack, vidout_ack, prev_in, prev_out);
            end
        end
        prev_in = vidin_ack;
        prev_out = vidout_ack;
    end

    function automatic logic [21:0] mkaddr(input logic [1:0] f, input logic [10:0] r,
                                           input logic [10:0] c);
        return {f, r[9:0], c[9:0]};
    endfunction

    task automatic clear_model();
        wexp.delete();
        rexp.delete();
        we_order.delete();
        gaps.delete();
    endtask

    task automatic wr_src(input logic [1:0] fr, input logic [10:0] row, input logic [10:0] col0,
                          input int n);
        int k = 0;
        int t = 0;
        vidin_frame = fr;
        vidin_row = row;
        vidin_col = col0;
        vidin_d = 16'($urandom);
        wexp.push_back({mkaddr(fr, row, col0), vidin_d});
        vidin_req = 1'b1;
        while (k < n) begin
            @(negedge clk_sys);
            t++;
            if (vidin_ack) begin
                k++;
                t = 0;
                checks++;
                if ($time - last_wr_ack != 10) begin
                    errors++;
                    $display("FAIL wr_ack_latency got %0t want 10", $time - last_wr_ack);
                end
                if (k < n) begin
                    vidin_col = vidin_col + 11'd1;
                    vidin_d = 16'($urandom);
                    wexp.push_back({mkaddr(fr, row, vidin_col), vidin_d});
                end
            end
            if (t > 400) begin
                errors++;
                $display("FAIL wr_timeout got %0d acks want %0d", k, n);
                break;
            end
        end
        vidin_req = 1'b0;
    endtask

    task automatic rd_src(input logic [1:0] fr, input logic [10:0] row, input logic [10:0] col0,
                          input int n);
        int k = 0;
        int t = 0;
        vidout_frame = fr;
        vidout_row = row;
        vidout_col = col0;
        rexp.push_back(mkaddr(fr, row, col0));
        vidout_req = 1'b1;
        while (k < n) begin
            @(negedge clk_sys);
            t++;
            if (vidout_ack) begin
                k++;
                t = 0;
                checks++;
                if (vidout_d !== (16'hA000 + {6'd0, vidout_col[9:0]}) ||
                    $time - last_rd_ack != 10) begin
                    errors++;
                    $display("FAIL rd_data got %h lat %0t want %h lat 10", vidout_d,
                             $time - last_rd_ack, 16'hA000 + {6'd0, vidout_col[9:0]});
                end
                if (k < n) begin
                    vidout_col = vidout_col + 11'd1;
                    rexp.push_back(mkaddr(fr, row, vidout_col));
                end
            end
            if (t > 400) begin
                errors++;
                $display("FAIL rd_timeout got %0d acks want %0d", k, n);
                break;
            end
        end
        vidout_req = 1'b0;
    endtask

    task automatic check_drained(input string name);
        repeat (3) @(negedge clk_sys);
        checks++;
        if (wexp.size() != 0 || rexp.size() != 0 || ram_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_drained got w=%0d r=%0d req=%b want 0 0 0", name, wexp.size(),
                     rexp.size(), ram_req);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({ram_req, ram_we, vidin_ack, vidout_ack, ram_addr, ram_wdata, vidout_d,
             stat_starve} !== '0) begin
            errors++;
            $display("FAIL %s got req=%b we=%b ia=%b oa=%b addr=%h wd=%h d=%h st=%h want all 0",
                     name, ram_req, ram_we, vidin_ack, vidout_ack, ram_addr, ram_wdata, vidout_d,
                     stat_starve);
        end
    endtask

    task automatic test_reset();
        #3;
        check_outputs_zero("reset_hold");
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        check_outputs_zero("reset_idle");
    endtask

    task automatic test_write_burst();
        clear_model();
        lat = 2;
        wr_src(2'd1, 11'd5, 11'd8, 8);
        check_drained("write_burst");
        checks++;
        if (gaps.size() != 8) begin
            errors++;
            $display("FAIL write_burst_count got %0d want 8", gaps.size());
        end
        for (int i = 1; i < gaps.size(); i++) begin
            checks++;
            if (gaps[i] != 1) begin
                errors++;
                $display("FAIL write_gap got %0d want 1 at word %0d", gaps[i], i);
            end
        end
    endtask

    task automatic test_read_burst();
        clear_model();
        lat = 2;
        rd_src(2'd0, 11'd3, 11'd0, 8);
        check_drained("read_burst");
        checks++;
        if (we_order.size() != 8) begin
            errors++;
            $display("FAIL read_burst_count got %0d want 8", we_order.size());
        end
    endtask

    task automatic test_burst_limits();
        clear_model();
        lat = $urandom_range(1, 3);
        wr_src(2'(2'($urandom)), 11'($urandom_range(0, 1023)), 11'($urandom_range(0, 900)), 20);
        check_drained("wr_limit");
        for (int i = 1; i < gaps.size(); i++) begin
            checks++;
            if (gaps[i] != ((i == 16) ? 2 : 1)) begin
                errors++;
                $display("FAIL wr_limit_gap got %0d want %0d at word %0d", gaps[i],
                         (i == 16) ? 2 : 1, i);
            end
        end
        clear_model();
        rd_src(2'(2'($urandom)), 11'($urandom_range(0, 1023)), 11'($urandom_range(0, 900)), 11);
        check_drained("rd_limit");
        for (int i = 1; i < gaps.size(); i++) begin
            checks++;
            if (gaps[i] != ((i == 8) ? 2 : 1)) begin
                errors++;
                $display("FAIL rd_limit_gap got %0d want %0d at word %0d", gaps[i],
                         (i == 8) ? 2 : 1, i);
            end
        end
    endtask

    task automatic check_order(input string name, input int nw_first, input int nr, input int nw);
        logic exp_bit;
        checks++;
        if (we_order.size() != nw_first + nr + nw) begin
            errors++;
            $display("FAIL %s_len got %0d want %0d", name, we_order.size(), nw_first + nr + nw);
        end else begin
            for (int i = 0; i < we_order.size(); i++) begin
                exp_bit = (i < nw_first) || (i >= nw_first + nr);
                checks++;
                if (we_order[i] !== exp_bit) begin
                    errors++;
                    $display("FAIL %s got we=%b want %b at txn %0d", name, we_order[i], exp_bit, i);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        clear_model();
        lat = 2;
        fork
            wr_src(2'd2, 11'd17, 11'd40, 5);
            rd_src(2'd3, 11'd9, 11'd100, 4);
        join
        check_drained("simultaneous");
        check_order("simul_order", 5, 4, 0);
    endtask

    task automatic test_read_abort();
        clear_model();
        lat = 2;
        fork
            rd_src(2'd1, 11'd2, 11'd64, 3);
            begin
                int t = 0;
                do begin @(negedge clk_sys); t++; end while (!vidout_ack && t < 200);
                do begin @(negedge clk_sys); t++; end while (!(ram_req && !ram_we) && t < 200);
                checks++;
                if (t >= 200) begin
                    errors++;
                    $display("FAIL read2_wait got timeout want read 2 issued");
                end
                wr_src(2'd0, 11'd30, 11'd7, 2);
            end
        join
        check_drained("read_abort");
        check_order("abort_order", 0, 3, 2);
    endtask

    task automatic test_drop_outstanding();
        int acks;
        int t;
        clear_model();
        lat = 3;
        vidout_frame = 2'd2;
        vidout_row = 11'd44;
        vidout_col = 11'd300;
        rexp.push_back(mkaddr(2'd2, 11'd44, 11'd300));
        vidout_req = 1'b1;
        t = 0;
        do begin @(negedge clk_sys); t++; end while (!ram_req && t < 20);
        vidout_req = 1'b0;
        acks = 0;
        repeat (15) begin @(negedge clk_sys); if (vidout_ack) acks++; end
        checks++;
        if (acks != 1 || we_order.size() != 1 || vidout_d !== 16'hA000 + 16'd300) begin
            errors++;
            $display("FAIL rd_drop got acks=%0d txns=%0d d=%h want 1 1 %h", acks, we_order.size(),
                     vidout_d, 16'hA000 + 16'd300);
        end
        clear_model();
        vidin_frame = 2'd3;
        vidin_row = 11'd12;
        vidin_col = 11'd500;
        vidin_d = 16'($urandom);
        wexp.push_back({mkaddr(2'd3, 11'd12, 11'd500), vidin_d});
        vidin_req = 1'b1;
        t = 0;
        do begin @(negedge clk_sys); t++; end while (!ram_req && t < 20);
        vidin_req = 1'b0;
        acks = 0;
        repeat (15) begin @(negedge clk_sys); if (vidin_ack) acks++; end
        checks++;
        if (acks != 1 || we_order.size() != 1) begin
            errors++;
            $display("FAIL wr_drop got acks=%0d txns=%0d want 1 1", acks, we_order.size());
        end
        check_drained("drop");
    endtask

    task automatic test_spurious_ack();
        clear_model();
        @(negedge clk_sys);
        #1 ram_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_sys);
            #1;
            checks++;
            if (ram_req !== 1'b0 || vidin_ack !== 1'b0 || vidout_ack !== 1'b0) begin
                errors++;
                $display("FAIL spurious_ack got req=%b ia=%b oa=%b want 0 0 0", ram_req,
                         vidin_ack, vidout_ack);
            end
        end
        lat = 1;
        wr_src(2'd1, 11'd1, 11'd1, 2);
        check_drained("after_spurious");
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int t = 0;
        clear_model();
        lat = 2;
        vidin_frame = 2'd0;
        vidin_row = 11'd7;
        vidin_col = 11'd100;
        vidin_d = 16'($urandom);
        wexp.push_back({mkaddr(2'd0, 11'd7, 11'd100), vidin_d});
        vidin_req = 1'b1;
        while (k < 3 && t < 200) begin
            @(negedge clk_sys);
            t++;
            if (vidin_ack) begin
                k++;
                vidin_col = vidin_col + 11'd1;
                vidin_d = 16'($urandom);
                wexp.push_back({mkaddr(2'd0, 11'd7, vidin_col), vidin_d});
            end
        end
        do begin @(negedge clk_sys); t++; end while (!ram_req && t < 200);
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("reset_async");
        vidin_req = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        clear_model();
        @(negedge clk_sys);
        wr_src(2'd0, 11'd7, 11'd50, 2);
        check_drained("reset_resume");
    endtask

    task automatic test_random();
        int mode;
        for (int it = 0; it < 12; it++) begin
            clear_model();
            lat = $urandom_range(1, 3);
            mode = $urandom_range(0, 2);
            case (mode)
                0: wr_src(2'($urandom), 11'($urandom_range(0, 1023)),
                          11'($urandom_range(0, 900)), $urandom_range(1, 20));
                1: rd_src(2'($urandom), 11'($urandom_range(0, 1023)),
                          11'($urandom_range(0, 900)), $urandom_range(1, 12));
                default: fork
                    wr_src(2'($urandom), 11'($urandom_range(0, 1023)),
                           11'($urandom_range(0, 900)), $urandom_range(1, 20));
                    rd_src(2'($urandom), 11'($urandom_range(0, 1023)),
                           11'($urandom_range(0, 900)), $urandom_range(1, 12));
                join
            endcase
            check_drained("random");
        end
    endtask

    task automatic test_starve();
        logic [15:0] exp_st;
`ifdef ROTATE_BRIDGE_STATS_EN
        exp_st = 16'd1;
`else
        exp_st = 16'd0;
`endif
        @(negedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        clear_model();
        lat = 3;
        fork
            rd_src(2'd1, 11'd20, 11'd0, 8);
            begin
                int t = 0;
                do begin @(negedge clk_sys); t++; end while (!(ram_req && !ram_we) && t < 50);
                wr_src(2'd1, 11'd21, 11'd0, 3);
            end
        join
        check_drained("starve");
        checks++;
        if (stat_starve !== exp_st) begin
            errors++;
            $display("FAIL stat_starve got %0d want %0d", stat_starve, exp_st);
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_burst_limits();
        test_simultaneous();
        test_read_abort();
        test_drop_outstanding();
        test_spurious_ack();
        test_reset_mid();
        test_random();
        test_starve();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
